tune_player: RTL

Table-driven piezo tune player that generalises the fixed fanfare driver behind KnightsTour's `piezo`/`piezo_n` pins. It holds a programmable note table and plays it on command. Each entry is a tone period plus a duration. The block adds per-tune length, rests, looping and abort, with a go/busy/done handshake. It sits between the command processor and the piezo pins; the default table reproduces the existing 6-note fanfare.

---
 rtl/tune_player_if.sv | 30 +++
 rtl/tune_player.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tune_player_if.sv
// Control, table-programming and piezo signals of the tune player, bundled as one port.
// The master side drives commands and table writes; the slave side is the player.
interface tune_player_if #(
   parameter int NOTE_W = 4,
   parameter int PER_W  = 15,
   parameter int DUR_W  = 25
);
   logic              cfg_we;
   logic [NOTE_W-1:0] cfg_addr;
   logic [PER_W-1:0]  cfg_period;
   logic [DUR_W-1:0]  cfg_dur;
   logic [NOTE_W-1:0] last_idx;
   logic              go;
   logic              loop;
   logic              abort;
   logic              busy;
   logic              done;
   logic              piezo;
   logic              piezo_n;

   modport master (
      output cfg_we, cfg_addr, cfg_period, cfg_dur, last_idx, go, loop, abort,
      input  busy, done, piezo, piezo_n
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_period, cfg_dur, last_idx, go, loop, abort,
      output busy, done, piezo, piezo_n
   );
endinterface

// File: rtl/tune_player.sv
// Table-driven piezo tune player: plays entries 0..last_idx of a programmable
// period/duration table, with rests, looping, abort and a go/busy/done handshake.
module tune_player #(
   parameter int NOTE_W   = 4,
   parameter int PER_W    = 15,
   parameter int DUR_W    = 25,
   parameter bit FAST_SIM = 1'b0
) (
   input logic          clk,
   input logic          rst_n,
   tune_player_if.slave bus
);
   localparam int DEPTH = 2 ** NOTE_W;
   localparam logic [DUR_W:0] STEP = FAST_SIM ? (DUR_W+1)'(16) : (DUR_W+1)'(1);

   typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

   function automatic logic [PER_W-1:0] def_period(input int i);
      case (i)
         32'sd0:  def_period = PER_W'(32'd31888);
         32'sd1:  def_period = PER_W'(32'd23890);
         32'sd2:  def_period = PER_W'(32'd18960);
         32'sd3:  def_period = PER_W'(32'd15944);
         32'sd4:  def_period = PER_W'(32'd18960);
         32'sd5:  def_period = PER_W'(32'd15944);
         default: def_period = {PER_W{1'b0}};
      endcase
   endfunction

   function automatic logic [DUR_W-1:0] def_dur(input int i);
      case (i)
         32'sd0:  def_dur = DUR_W'(32'd8388608);
         32'sd1:  def_dur = DUR_W'(32'd8388608);
         32'sd2:  def_dur = DUR_W'(32'd8388608);
         32'sd3:  def_dur = DUR_W'(32'd12582912);
         32'sd4:  def_dur = DUR_W'(32'd4194304);
         32'sd5:  def_dur = DUR_W'(32'd16777216);
         default: def_dur = {DUR_W{1'b0}};
      endcase
   endfunction

   logic [PER_W-1:0]  per_tab_r [DEPTH];
   logic [DUR_W-1:0]  dur_tab_r [DEPTH];

   state_t            state_r, state_s;
   logic [NOTE_W-1:0] idx_r, idx_s;
   logic [NOTE_W-1:0] last_r, last_s;
   logic [PER_W-1:0]  per_r, per_s;
   logic [DUR_W-1:0]  dur_r, dur_s;
   logic [PER_W-1:0]  pc_r, pc_s;
   logic [DUR_W-1:0]  dc_r, dc_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              piezo_r, piezo_s;
   logic              piezo_n_r, piezo_n_s;
   logic              pc_wrap_s;
   logic              note_end_s;

   // Note table: reset restores the fanfare; writes land in any state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 32'sd0; i < DEPTH; i++) begin
            per_tab_r[i] <= def_period(i);
            dur_tab_r[i] <= def_dur(i);
         end
      end else if (bus.cfg_we) begin
         per_tab_r[bus.cfg_addr] <= bus.cfg_period;
         dur_tab_r[bus.cfg_addr] <= bus.cfg_dur;
      end
   end

   // Next-state, note sequencing and next output values.
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      last_s     = last_r;
      per_s      = per_r;
      dur_s      = dur_r;
      pc_s       = pc_r;
      dc_s       = dc_r;
      done_s     = 1'b0;
      pc_wrap_s  = ({1'b0, pc_r} + (PER_W+1)'(1'b1)) >= {1'b0, per_r};
      note_end_s = ({1'b0, dc_r} + STEP) >= {1'b0, dur_r};
      case (state_r)
         IDLE: begin
            if (bus.go && !bus.abort) begin
               state_s = PLAY;
               last_s  = bus.last_idx;
               idx_s   = {NOTE_W{1'b0}};
               per_s   = per_tab_r[0];
               dur_s   = dur_tab_r[0];
               pc_s    = {PER_W{1'b0}};
               dc_s    = {DUR_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         PLAY: begin
            if (bus.abort) begin
               state_s = IDLE;
            end else if (note_end_s) begin
               // Table reads see the pre-edge contents, so a same-cycle write loads the old entry.
               pc_s = {PER_W{1'b0}};
               dc_s = {DUR_W{1'b0}};
               if (idx_r != last_r) begin
                  idx_s = idx_r + NOTE_W'(1'b1);
                  per_s = per_tab_r[idx_r + NOTE_W'(1'b1)];
                  dur_s = dur_tab_r[idx_r + NOTE_W'(1'b1)];
               end else if (bus.loop) begin
                  idx_s = {NOTE_W{1'b0}};
                  per_s = per_tab_r[0];
                  dur_s = dur_tab_r[0];
               end else begin
                  state_s = IDLE;
                  done_s  = 1'b1;
               end
            end else begin
               pc_s = pc_wrap_s ? {PER_W{1'b0}} : pc_r + PER_W'(1'b1);
               dc_s = dc_r + STEP[DUR_W-1:0];
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s    = (state_s == PLAY);
      piezo_s   = busy_s && (pc_s < (per_s >> 1));
      piezo_n_s = busy_s && (per_s != {PER_W{1'b0}}) && !piezo_s;
   end

   // Playback state and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         idx_r     <= {NOTE_W{1'b0}};
         last_r    <= {NOTE_W{1'b0}};
         per_r     <= {PER_W{1'b0}};
         dur_r     <= {DUR_W{1'b0}};
         pc_r      <= {PER_W{1'b0}};
         dc_r      <= {DUR_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         piezo_r   <= 1'b0;
         piezo_n_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         last_r    <= last_s;
         per_r     <= per_s;
         dur_r     <= dur_s;
         pc_r      <= pc_s;
         dc_r      <= dc_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         piezo_r   <= piezo_s;
         piezo_n_r <= piezo_n_s;
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.piezo   = piezo_r;
   assign bus.piezo_n = piezo_n_r;
endmodule
